// File: rtl/mask_bbox_tracker.sv
// mask_bbox_tracker: per-frame bounding box and area of foreground mask pixels, latched on vsync rise.
// Latency: video/timing outputs 1 enabled cycle; bbox results and frame_done update on the vsync rising-edge cycle.
// Backpressure: none (streaming pixel pipe); ce=0 freezes all state. Macro BBOX_OVERLAY_EN draws the latched box in red.
module mask_bbox_tracker #(
    parameter int X_WIDTH  = 11,
    parameter int Y_WIDTH  = 11,
    parameter int MIN_AREA = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic [7:0]         in_mask,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_de,
    output logic [7:0]         out_red,
    output logic [7:0]         out_green,
    output logic [7:0]         out_blue,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_de,
    output logic [X_WIDTH-1:0] bbox_xmin,
    output logic [X_WIDTH-1:0] bbox_xmax,
    output logic [Y_WIDTH-1:0] bbox_ymin,
    output logic [Y_WIDTH-1:0] bbox_ymax,
    output logic [21:0]        bbox_area,
    output logic               bbox_valid,
    output logic               frame_done
);

    localparam logic [X_WIDTH-1:0] X_ONES     = '1;
    localparam logic [Y_WIDTH-1:0] Y_ONES     = '1;
    localparam logic [21:0]        AREA_ONES  = '1;
    localparam logic [22:0]        MIN_AREA_V = 23'(MIN_AREA);

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACCUM      = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic               de_q;
    logic               vsync_q;
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;
    logic [X_WIDTH-1:0] acc_xmin_q;
    logic [X_WIDTH-1:0] acc_xmax_q;
    logic [Y_WIDTH-1:0] acc_ymin_q;
    logic [Y_WIDTH-1:0] acc_ymax_q;
    logic [21:0]        acc_area_q;

    logic vsync_rise;
    logic de_fall;
    logic pix_fg;
    logic area_ok;
    logic accum_en;
    logic do_latch;
    logic [7:0] pix_red;
    logic [7:0] pix_green;
    logic [7:0] pix_blue;

    // Pixels arriving while vsync is high never count as foreground.
    always_comb begin
        vsync_rise = in_vsync & ~vsync_q;
        de_fall    = de_q & ~in_de;
        pix_fg     = in_de & ~in_vsync & in_mask[7];
        area_ok    = {1'b0, acc_area_q} >= MIN_AREA_V;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_FRAME;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accum_en = 1'b0;
        do_latch = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (vsync_rise) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                accum_en = 1'b1;
                do_latch = vsync_rise;
            end
            default: begin
                state_d = WAIT_FRAME;
            end
        endcase
    end

    // Pixel position counters; both saturate so oversized frames cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q    <= 1'b0;
            vsync_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (ce) begin
            de_q    <= in_de;
            vsync_q <= in_vsync;
            if (in_de) begin
                if (x_q != X_ONES) begin
                    x_q <= x_q + 1'b1;
                end
            end else begin
                x_q <= '0;
            end
            if (vsync_rise) begin
                y_q <= '0;
            end else if (de_fall && (y_q != Y_ONES)) begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_xmin_q <= X_ONES;
            acc_xmax_q <= '0;
            acc_ymin_q <= Y_ONES;
            acc_ymax_q <= '0;
            acc_area_q <= '0;
        end else if (ce) begin
            if (vsync_rise) begin
                acc_xmin_q <= X_ONES;
                acc_xmax_q <= '0;
                acc_ymin_q <= Y_ONES;
                acc_ymax_q <= '0;
                acc_area_q <= '0;
            end else if (accum_en && pix_fg) begin
                if (x_q < acc_xmin_q) acc_xmin_q <= x_q;
                if (x_q > acc_xmax_q) acc_xmax_q <= x_q;
                if (y_q < acc_ymin_q) acc_ymin_q <= y_q;
                if (y_q > acc_ymax_q) acc_ymax_q <= y_q;
                if (acc_area_q != AREA_ONES) begin
                    acc_area_q <= acc_area_q + 1'b1;
                end
            end
        end
    end

    // An undersized frame still reports its pixel count, but with an empty box.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            bbox_area  <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
        end else if (ce) begin
            frame_done <= do_latch;
            if (do_latch) begin
                bbox_area <= acc_area_q;
                if (area_ok) begin
                    bbox_xmin  <= acc_xmin_q;
                    bbox_xmax  <= acc_xmax_q;
                    bbox_ymin  <= acc_ymin_q;
                    bbox_ymax  <= acc_ymax_q;
                    bbox_valid <= 1'b1;
                end else begin
                    bbox_xmin  <= '0;
                    bbox_xmax  <= '0;
                    bbox_ymin  <= '0;
                    bbox_ymax  <= '0;
                    bbox_valid <= 1'b0;
                end
            end
        end
    end

`ifdef BBOX_OVERLAY_EN
    logic on_col;
    logic on_row;
    logic on_border;

    // Border test uses the previous frame's latched box against the live pixel position.
    always_comb begin
        on_col    = ((x_q == bbox_xmin) || (x_q == bbox_xmax)) &&
                    (y_q >= bbox_ymin) && (y_q <= bbox_ymax);
        on_row    = ((y_q == bbox_ymin) || (y_q == bbox_ymax)) &&
                    (x_q >= bbox_xmin) && (x_q <= bbox_xmax);
        on_border = in_de && bbox_valid && (on_col || on_row);
        pix_red   = on_border ? 8'hFF : in_mask;
        pix_green = on_border ? 8'h00 : in_mask;
        pix_blue  = on_border ? 8'h00 : in_mask;
    end
`else
    always_comb begin
        pix_red   = in_mask;
        pix_green = in_mask;
        pix_blue  = in_mask;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
        end else if (ce) begin
            out_red   <= pix_red;
            out_green <= pix_green;
            out_blue  <= pix_blue;
            out_hsync <= in_hsync;
            out_vsync <= in_vsync;
            out_de    <= in_de;
        end
    end

endmodule

// File: tb/tb_mask_bbox_tracker.sv
// Bench for mask_bbox_tracker: two instances (MIN_AREA 16 and 1) share one 64x48 video stream,
// checked against a frame-level box/area model computed from the pixel array.
module tb_mask_bbox_tracker;

    localparam int W = 64;
    localparam int H = 48;

    typedef struct packed {
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [10:0] ymin;
        logic [10:0] ymax;
        logic [21:0] area;
        logic        valid;
    } bb_t;

    logic clk;
    logic rst_n;
    logic ce;
    logic [7:0] in_mask;
    logic in_hsync;
    logic in_vsync;
    logic in_de;

    logic [7:0]  o_red   [2];
    logic [7:0]  o_green [2];
    logic [7:0]  o_blue  [2];
    logic        o_hs    [2];
    logic        o_vs    [2];
    logic        o_de    [2];
    logic [10:0] o_xmin  [2];
    logic [10:0] o_xmax  [2];
    logic [10:0] o_ymin  [2];
    logic [10:0] o_ymax  [2];
    logic [21:0] o_area  [2];
    logic        o_valid [2];
    logic        o_fd    [2];

    logic [7:0] pix [H][W];
    bb_t lat [2];
    int  min_area_of [2];
    int  fd [2];
    int  n_assert;
    int  n_fail;

    mask_bbox_tracker #(.X_WIDTH(11), .Y_WIDTH(11), .MIN_AREA(16)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_mask(in_mask),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .out_red(o_red[0]), .out_green(o_green[0]), .out_blue(o_blue[0]),
        .out_hsync(o_hs[0]), .out_vsync(o_vs[0]), .out_de(o_de[0]),
        .bbox_xmin(o_xmin[0]), .bbox_xmax(o_xmax[0]),
        .bbox_ymin(o_ymin[0]), .bbox_ymax(o_ymax[0]),
        .bbox_area(o_area[0]), .bbox_valid(o_valid[0]), .frame_done(o_fd[0])
    );

    mask_bbox_tracker #(.X_WIDTH(11), .Y_WIDTH(11), .MIN_AREA(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_mask(in_mask),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .out_red(o_red[1]), .out_green(o_green[1]), .out_blue(o_blue[1]),
        .out_hsync(o_hs[1]), .out_vsync(o_vs[1]), .out_de(o_de[1]),
        .bbox_xmin(o_xmin[1]), .bbox_xmax(o_xmax[1]),
        .bbox_ymin(o_ymin[1]), .bbox_ymax(o_ymax[1]),
        .bbox_area(o_area[1]), .bbox_valid(o_valid[1]), .frame_done(o_fd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bb_t model(input int ma);
        bb_t b;
        int xmn, xmx, ymn, ymx, area;
        xmn = 1 << 30; xmx = -1; ymn = 1 << 30; ymx = -1; area = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (pix[y][x][7]) begin
                    area++;
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
            end
        end
        b = '0;
        b.area = 22'(area);
        if (area >= ma) begin
            b.xmin = 11'(xmn); b.xmax = 11'(xmx);
            b.ymin = 11'(ymn); b.ymax = 11'(ymx);
            b.valid = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [26:0] exp_vid(input int i, input logic [7:0] m, input logic h,
                                            input logic v, input logic de, input int px, input int py);
        logic [7:0] r, g, b;
        r = m; g = m; b = m;
`ifdef BBOX_OVERLAY_EN
        if (de && lat[i].valid) begin
            if ((((px == int'(lat[i].xmin)) || (px == int'(lat[i].xmax))) &&
                 (py >= int'(lat[i].ymin)) && (py <= int'(lat[i].ymax))) ||
                (((py == int'(lat[i].ymin)) || (py == int'(lat[i].ymax))) &&
                 (px >= int'(lat[i].xmin)) && (px <= int'(lat[i].xmax)))) begin
                r = 8'hFF; g = 8'h00; b = 8'h00;
            end
        end
`endif
        return {r, g, b, h, v, de};
    endfunction

    function automatic logic [26:0] obs_vid(input int i);
        return {o_red[i], o_green[i], o_blue[i], o_hs[i], o_vs[i], o_de[i]};
    endfunction

    function automatic logic [67:0] obs_state(input int i);
        return {o_xmin[i], o_xmax[i], o_ymin[i], o_ymax[i], o_area[i], o_valid[i], o_fd[i]};
    endfunction

    // One enabled clock with the given inputs; video out must echo them one cycle later.
    task automatic cyc(input logic [7:0] m, input logic h, input logic v, input logic de,
                       input int px, input int py);
        in_mask = m; in_hsync = h; in_vsync = v; in_de = de;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("video%0d", i), 128'(obs_vid(i)), 128'(exp_vid(i, m, h, v, de, px, py)));
            if (o_fd[i]) fd[i]++;
        end
    endtask

    task automatic stall5();
        logic [26:0] sv_vid [2];
        logic [67:0] sv_st  [2];
        for (int i = 0; i < 2; i++) begin
            sv_vid[i] = obs_vid(i);
            sv_st[i]  = obs_state(i);
        end
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_mask  = 8'($urandom_range(0, 255));
            in_de    = 1'($urandom_range(0, 1));
            in_hsync = 1'($urandom_range(0, 1));
            in_vsync = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("ce_hold_vid%0d", i), 128'(obs_vid(i)), 128'(sv_vid[i]));
                check($sformatf("ce_hold_state%0d", i), 128'(obs_state(i)), 128'(sv_st[i]));
            end
        end
        ce = 1'b1;
    endtask

    task automatic send_lines(input int stall_line, input int rst_line);
        for (int l = 0; l < H; l++) begin
            if (l == rst_line) begin
                rst_n = 1'b0;
                #2;
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("midrst_vid%0d", i), 128'(obs_vid(i)), 128'(0));
                    check($sformatf("midrst_state%0d", i), 128'(obs_state(i)), 128'(0));
                    lat[i] = '0;
                end
                #1;
                rst_n = 1'b1;
            end
            for (int c = 0; c < 4; c++) cyc(8'h00, 1'b1, 1'b0, 1'b0, -1, -1);
            for (int c = 0; c < W; c++) begin
                if ((l == stall_line) && (c == 30)) stall5();
                cyc(pix[l][c], 1'b0, 1'b0, 1'b1, c, l);
            end
        end
        for (int c = 0; c < 4; c++) cyc(8'h00, 1'b1, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic vsync_pulse(input int exp_pulses);
        fd[0] = 0; fd[1] = 0;
        cyc(8'h00, 1'b0, 1'b1, 1'b0, -1, -1);
        cyc(8'h00, 1'b0, 1'b1, 1'b0, -1, -1);
        for (int c = 0; c < W + 4; c++) cyc(8'h00, 1'b1, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("frame_done_count%0d", i), 128'(fd[i]), 128'(exp_pulses));
        end
    endtask

    task automatic check_bbox(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_box%0d", tag, i),
                  128'({o_xmin[i], o_xmax[i], o_ymin[i], o_ymax[i]}),
                  128'({lat[i].xmin, lat[i].xmax, lat[i].ymin, lat[i].ymax}));
            check($sformatf("%s_area_valid%0d", tag, i),
                  128'({o_area[i], o_valid[i]}), 128'({lat[i].area, lat[i].valid}));
        end
    endtask

    task automatic clear_pix();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = 8'h00;
    endtask

    task automatic draw_rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                pix[y][x] = 8'hFF;
    endtask

    task automatic fill_random(input int dens, input bit rect);
        int x0, y0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = (int'($urandom_range(0, 99)) < dens) ? 8'($urandom_range(128, 255))
                                                                  : 8'($urandom_range(0, 127));
        if (rect) begin
            x0 = int'($urandom_range(0, W - 8));
            y0 = int'($urandom_range(0, H - 6));
            draw_rect(x0, x0 + int'($urandom_range(0, 7)), y0, y0 + int'($urandom_range(0, 5)));
        end
    endtask

    task automatic run_frame(input string tag, input int stall_line);
        send_lines(stall_line, -1);
        for (int i = 0; i < 2; i++) lat[i] = model(min_area_of[i]);
        vsync_pulse(1);
        check_bbox(tag);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        min_area_of[0] = 16; min_area_of[1] = 1;
        lat[0] = '0; lat[1] = '0;
        rst_n = 1'b0; ce = 1'b1;
        in_mask = 8'h00; in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
        #23;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_vid%0d", i), 128'(obs_vid(i)), 128'(0));
            check($sformatf("reset_state%0d", i), 128'(obs_state(i)), 128'(0));
        end
        rst_n = 1'b1;

        // First vsync only arms accumulation.
        vsync_pulse(0);
        check_bbox("arm");

        clear_pix();
        pix[5][10] = 8'hFF;
        run_frame("single_px", -1);

        clear_pix();
        draw_rect(20, 29, 8, 15);
        run_frame("block", -1);

        // Drawn with the block's box latched: (20,10) is on the border, (25,10) is not.
        clear_pix();
        run_frame("empty", -1);

        for (int k = 0; k < 5; k++) begin
            fill_random(k, k[0]);
            run_frame("random", -1);
        end

        // Reset mid-frame after 50 foreground pixels: that frame and the next vsync produce nothing.
        clear_pix();
        draw_rect(0, 9, 0, 4);
        draw_rect(40, 50, 30, 40);
        send_lines(-1, 6);
        vsync_pulse(0);
        check_bbox("after_rst");
        clear_pix();
        draw_rect(20, 29, 8, 15);
        run_frame("post_rst", -1);

        fill_random(2, 1'b1);
        run_frame("ce_stall", 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
